nd_stream_buffer: RTL
=====================

# nd_stream_buffer

Elastic buffer placed directly downstream of the DSP qa stage in the UHD chain. It accepts `in_data`/`in_nd` samples, which arrive with no backpressure, stores them in a circular FIFO, and releases them one per cycle while the consumer asserts `out_rdy`. Samples that arrive when the buffer is full are dropped and flagged with a sticky overflow.

## Interface
- `WDTH`, default 32: sample width in bits.
- `DEPTH_LOG2`, default 4: log2 of FIFO depth; depth = 2^DEPTH_LOG2 = 16.

- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state immediately.
- `in_data`  in  WDTH: sample from upstream; valid only when `in_nd`=1.
- `in_nd`  in  1: new-data strobe; one sample per high cycle.
- `out_rdy`  in  1: consumer may accept a sample this cycle.
- `out_data`  out  WDTH: registered output sample.
- `out_nd`  out  1: registered; high for exactly one cycle per delivered sample.
- `fill`  out  DEPTH_LOG2+1: current number of stored words, 0..2^DEPTH_LOG2.
- `overflow`  out  1: sticky; set when a sample is dropped.

## Operation
- Storage:
  - 2^DEPTH_LOG2 x WDTH array.
  - Write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits, wrap modulo depth.
  - Count register `fill` with one extra bit so full and empty are distinguishable.
- Write: on an edge with `in_nd`=1 and (`fill` < depth, or a read on the same edge):
  - store `in_data` at `wp`;
  - `wp`++.
- Read: on an edge with `out_rdy`=1 and `fill` > 0:
  - `out_data` <= mem[`rp`];
  - `rp`++;
  - `out_nd` <= 1.
  - Otherwise `out_nd` <= 0 and `out_data` holds its last value.
- `fill` update per edge: `fill` + write − read.
  - Simultaneous read and write leaves `fill` unchanged, including when full.
- Drop: `in_nd`=1, `fill` = depth, and no read on the same edge.
  - The sample is discarded.
  - `wp` and `fill` are unchanged.
  - `overflow` <= 1 and stays set until `reset`.
- Read empty: `out_rdy`=1 with `fill`=0 produces no output and no error.
- Same-edge write and read into an empty FIFO:
  - The read is not granted, because `fill` was 0 at that edge.
  - No write-through bypass.
- Reset (asynchronous, including mid-stream):
  - `wp`=`rp`=0, `fill`=0, `out_nd`=0, `out_data`=0, `overflow`=0.
  - Array contents are don't-care.
  - In-flight samples are lost.

## Timing
- Reset values: `out_data`=0, `out_nd`=0, `fill`=0, `overflow`=0.
- Latency: a sample captured on edge k with `out_rdy` held high appears on `out_data`/`out_nd` after edge k+1, i.e. 2-cycle latency.
- Throughput: one sample per cycle sustained when `in_nd` and `out_rdy` are both continuously high.
- Ordering: strict FIFO; no reordering, no duplication.
- `fill` and `overflow` are registered and reflect the state after the most recent edge.
- `out_rdy` is sampled only at the edge; it has no combinational path to any output.

## Structure
- The shared include header holds the default `WDTH` and `DEPTH_LOG2` so neighbouring UHD-chain blocks agree on sample width.
- One sub-module, `nd_buffer_ram`:
  - simple dual-port memory: one write port, one registered-read port;
  - parameterised by WDTH and DEPTH_LOG2.
- Pointers, count, overflow and handshake logic live in `nd_stream_buffer`.
- Target size: about 150 lines of RTL in total.

## Test plan
- Reset then idle, 20 cycles with `in_nd`=0 and `out_rdy`=1 -> `out_nd` never high, `fill`=0, `overflow`=0.
- Pass-through: `out_rdy`=1, write 0x1, 0x2, 0x3 on consecutive cycles -> `out_nd` high for 3 consecutive cycles, starting 2 cycles after the first write, with data 0x1, 0x2, 0x3.
- Fill and drain: `out_rdy`=0, write 0x00..0x0F (16 words) -> `fill`=16, `overflow`=0. Then `out_rdy`=1 -> 16 outputs in order 0x00..0x0F, then `fill`=0.
- Overflow: from full, write 0xAA with `out_rdy`=0 -> `overflow`=1, `fill` stays 16. Drain -> 0xAA never appears. `overflow` stays 1 until `reset`.
- Simultaneous read/write at full: `fill`=16, `in_nd`=`out_rdy`=1 for 10 cycles with data 0x100..0x109 -> `fill` stays 16, `overflow`=0. All 26 words are eventually output in order.
- Mid-stream reset: `fill`=5, assert `reset` between edges -> `out_nd`, `fill`, `overflow` read 0 immediately. After release, write 0x55 -> first output is 0x55.

Source files
------------

// File: rtl/nd_stream_buffer_pkg.sv
// Shared defaults for the nd_stream_buffer slice.
// Neighbouring UHD-chain blocks import these so sample widths agree.
package nd_stream_buffer_pkg;

  localparam int ND_WDTH       = 32;
  localparam int ND_DEPTH_LOG2 = 4;

endpackage

// File: rtl/nd_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset and holds when no read is issued.
module nd_buffer_ram
  import nd_stream_buffer_pkg::*;
#(
  parameter int WDTH       = ND_WDTH,
  parameter int DEPTH_LOG2 = ND_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [WDTH-1:0]       i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [WDTH-1:0]       o_rdata
);

  logic [WDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WDTH-1:0] r_rdata;

  // Array write; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read; a same-address write returns the old word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/nd_stream_buffer.sv
// Elastic FIFO after the DSP qa stage: no input backpressure,
// drops samples when full and flags a sticky overflow.
module nd_stream_buffer
  import nd_stream_buffer_pkg::*;
#(
  parameter int WDTH       = ND_WDTH,
  parameter int DEPTH_LOG2 = ND_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WDTH-1:0]       in_data,
  input  logic                  in_nd,
  input  logic                  out_rdy,
  output logic [WDTH-1:0]       out_data,
  output logic                  out_nd,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  overflow
);

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_fill;
  logic                  r_out_nd;
  logic                  r_overflow;

  logic w_rd;
  logic w_wr;
  logic w_drop;
  logic w_full;

  assign w_full = (r_fill == FULL);
  assign w_rd   = out_rdy && (r_fill != '0);
  assign w_wr   = in_nd && (!w_full || w_rd);
  assign w_drop = in_nd && w_full && !w_rd;

  nd_buffer_ram #(
    .WDTH       (WDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_we    (w_wr),
    .i_waddr (r_wp),
    .i_wdata (in_data),
    .i_re    (w_rd),
    .i_raddr (r_rp),
    .o_rdata (out_data)
  );

  // Pointer, occupancy, strobe and sticky-overflow bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_fill     <= '0;
      r_out_nd   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_out_nd <= w_rd;
      if (w_wr) r_wp <= r_wp + DEPTH_LOG2'(1);
      if (w_rd) r_rp <= r_rp + DEPTH_LOG2'(1);
      if (w_wr && !w_rd) begin
        r_fill <= r_fill + (DEPTH_LOG2 + 1)'(1);
      end else if (w_rd && !w_wr) begin
        r_fill <= r_fill - (DEPTH_LOG2 + 1)'(1);
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign out_nd   = r_out_nd;
  assign fill     = r_fill;
  assign overflow = r_overflow;

endmodule
